// File: rtl/md5_search_ctrl.sv
// md5_search_ctrl: issues LANES consecutive candidates per cycle over a loaded range and captures the first hash match.
// Optional macro SEARCH_CTRL_CONTINUE_EN: scan the whole range after a match and count matches on found_count.
module md5_search_ctrl #(
   parameter int LANES    = 4,
   parameter int COUNT_W  = 32,
   parameter int PIPE_LAT = 64
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     step,
   input  logic                     load,
   input  logic [COUNT_W-1:0]       start_value,
   input  logic [COUNT_W-1:0]       end_value,
   output logic [LANES*COUNT_W-1:0] lane_cand,
   output logic [LANES-1:0]         lane_valid,
   input  logic [LANES-1:0]         ret_valid,
   input  logic [LANES-1:0]         ret_found,
   input  logic [LANES*COUNT_W-1:0] ret_cand,
   output logic                     found,
   output logic [COUNT_W-1:0]       found_value,
`ifdef SEARCH_CTRL_CONTINUE_EN
   output logic [15:0]              found_count,
`endif
   output logic                     running,
   output logic                     done
);
   localparam int CW1    = COUNT_W + 1;
   localparam int DCNT_W = $clog2(PIPE_LAT + 1);

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FOUND} state_t;

   state_t             state, state_nx;
   logic [CW1-1:0]     base, end_r;
   logic [DCNT_W-1:0]  drain_cnt;
   logic [CW1-1:0]     batch_sum [LANES];
   logic               hit, accept, issue, do_load, last_batch, drain_exp, range_ok;
   logic [COUNT_W-1:0] hit_value;

   // One extra bit keeps base+i and the end compare free of wrap at the top of the range.
   always_comb begin
      for (int i = 0; i < LANES; i++) batch_sum[i] = base + CW1'(i);
   end

   // Scan downward so the lowest matching lane is the one left standing.
   always_comb begin
      hit       = 1'b0;
      hit_value = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (ret_valid[i] && ret_found[i]) begin
            hit       = 1'b1;
            hit_value = ret_cand[i*COUNT_W +: COUNT_W];
         end
      end
   end

   assign accept     = hit && ((state == RUN) || (state == DRAIN));
   assign last_batch = (base + CW1'(LANES)) > end_r;
   assign drain_exp  = (drain_cnt == DCNT_W'(PIPE_LAT - 1));
   assign range_ok   = (start_value <= end_value);
   assign running    = (state == RUN) || (state == DRAIN);
   assign done       = (state == DONE);

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      do_load  = 1'b0;
      case (state)
         IDLE, DONE, FOUND: begin
            if (load) begin
               do_load  = 1'b1;
               state_nx = range_ok ? RUN : DONE;
            end
         end
         RUN: begin
`ifdef SEARCH_CTRL_CONTINUE_EN
            if (enable || step) begin
               issue = 1'b1;
               if (last_batch) state_nx = DRAIN;
            end
`else
            if (accept) begin
               state_nx = FOUND;
            end else if (enable || step) begin
               issue = 1'b1;
               if (last_batch) state_nx = DRAIN;
            end
`endif
         end
         DRAIN: begin
`ifdef SEARCH_CTRL_CONTINUE_EN
            if (drain_exp) state_nx = ((found_count != 16'd0) || accept) ? FOUND : DONE;
`else
            if (accept)         state_nx = FOUND;
            else if (drain_exp) state_nx = DONE;
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         base        <= '0;
         end_r       <= '0;
         drain_cnt   <= '0;
         lane_cand   <= '0;
         lane_valid  <= '0;
         found       <= 1'b0;
         found_value <= '0;
`ifdef SEARCH_CTRL_CONTINUE_EN
         found_count <= '0;
`endif
      end else begin
         state      <= state_nx;
         drain_cnt  <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
         lane_valid <= '0;
         if (do_load) begin
            base        <= {1'b0, start_value};
            end_r       <= {1'b0, end_value};
            found       <= 1'b0;
            found_value <= '0;
`ifdef SEARCH_CTRL_CONTINUE_EN
            found_count <= '0;
`endif
         end
         if (issue) begin
            for (int i = 0; i < LANES; i++) begin
               lane_cand[i*COUNT_W +: COUNT_W] <= batch_sum[i][COUNT_W-1:0];
               lane_valid[i]                   <= (batch_sum[i] <= end_r);
            end
            base <= base + CW1'(LANES);
         end
         if (accept && !found) begin
            found       <= 1'b1;
            found_value <= hit_value;
         end
`ifdef SEARCH_CTRL_CONTINUE_EN
         if (accept && (found_count != 16'hFFFF)) found_count <= found_count + 16'd1;
`endif
      end
   end

endmodule
